// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush/switch generator for the 5-stage pipeline.
// Priority: trap redirect, memory wait, load-use bubble, taken-jump flush.
module pipe_hazard_ctrl #(
    parameter int CNT_W  = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] ID_rs1_addr,
    input  logic [REG_AW-1:0] ID_rs2_addr,
    input  logic              ID_use_rs1,
    input  logic              ID_use_rs2,
    input  logic [REG_AW-1:0] EX_rd_addr,
    input  logic              EX_mem_read,
    input  logic              EX_valid,
    input  logic              EX_jump,
    input  logic              imem_busy,
    input  logic              dmem_busy,
    input  logic              trap_req,
    output logic              pc_halt,
    output logic              if_id_halt,
    output logic              if_id_flush,
    output logic              id_ex_halt,
    output logic              id_ex_flush,
    output logic              ex_mem_halt,
    output logic              ex_mem_flush,
    output logic              switch,
    output logic              pc_redirect_trap,
    output logic              pc_redirect_jump,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    typedef enum logic [1:0] {RUN, DRAIN, SWITCH} state_t;

    state_t state, state_nxt;
    logic   pending, pending_nxt;
    logic   load_use;
    logic   any_flush;

    assign load_use = EX_valid && EX_mem_read && (EX_rd_addr != '0) &&
                      ((ID_use_rs1 && (ID_rs1_addr == EX_rd_addr)) ||
                       (ID_use_rs2 && (ID_rs2_addr == EX_rd_addr)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= RUN;
            pending <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            state   <= state_nxt;
            pending <= pending_nxt;
        end
    end

    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        state_nxt        = state;
        pending_nxt      = pending;
        pc_halt          = 1'b0;
        if_id_halt       = 1'b0;
        if_id_flush      = 1'b0;
        id_ex_halt       = 1'b0;
        id_ex_flush      = 1'b0;
        ex_mem_halt      = 1'b0;
        ex_mem_flush     = 1'b0;
        switch           = 1'b0;
        pc_redirect_trap = 1'b0;
        pc_redirect_jump = 1'b0;

        unique case (state)
            RUN: begin
                if (trap_req && dmem_busy) begin
                    state_nxt   = DRAIN;
                    pending_nxt = 1'b1;
                    pc_halt     = 1'b1;
                    if_id_halt  = 1'b1;
                    id_ex_halt  = 1'b1;
                    ex_mem_halt = 1'b1;
                end else if (trap_req) begin
                    state_nxt = SWITCH;
                end else if (imem_busy || dmem_busy) begin
                    pc_halt     = 1'b1;
                    if_id_halt  = 1'b1;
                    id_ex_halt  = 1'b1;
                    ex_mem_halt = 1'b1;
                end else if (load_use) begin
                    pc_halt     = 1'b1;
                    if_id_halt  = 1'b1;
                    id_ex_flush = 1'b1;
                end else if (EX_jump) begin
                    if_id_flush      = 1'b1;
                    id_ex_flush      = 1'b1;
                    pc_redirect_jump = 1'b1;
                end
            end
            DRAIN: begin
                // Hold everything until the outstanding data access retires.
                pc_halt     = 1'b1;
                if_id_halt  = 1'b1;
                id_ex_halt  = 1'b1;
                ex_mem_halt = 1'b1;
                if (!dmem_busy) state_nxt = pending ? SWITCH : RUN;
            end
            SWITCH: begin
                switch           = 1'b1;
                pc_redirect_trap = 1'b1;
                state_nxt        = RUN;
                pending_nxt      = 1'b0;
            end
            default: begin
                state_nxt   = RUN;
                pending_nxt = 1'b0;
            end
        endcase

        // Reset forces every pipeline register to clear, independent of the clock.
        if (rst) begin
            pc_halt          = 1'b0;
            if_id_halt       = 1'b0;
            id_ex_halt       = 1'b0;
            ex_mem_halt      = 1'b0;
            if_id_flush      = 1'b1;
            id_ex_flush      = 1'b1;
            ex_mem_flush     = 1'b1;
            switch           = 1'b0;
            pc_redirect_trap = 1'b0;
            pc_redirect_jump = 1'b0;
        end
    end

    assign any_flush = if_id_flush || id_ex_flush || ex_mem_flush || switch;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (pc_halt && (stall_cnt != '1))   stall_cnt <= stall_cnt + 1'b1;
            if (any_flush && (flush_cnt != '1)) flush_cnt <= flush_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl; narrow counters make saturation reachable.
module tb_pipe_hazard_ctrl;

    localparam int CNT_W  = 4;
    localparam int REG_AW = 5;

    // Output vector order: pc_halt, if_id_halt, if_id_flush, id_ex_halt, id_ex_flush,
    // ex_mem_halt, ex_mem_flush, switch, pc_redirect_trap, pc_redirect_jump
    localparam logic [9:0] O_NONE  = 10'b00_0000_0000;
    localparam logic [9:0] O_LDUSE = 10'b11_0010_0000;
    localparam logic [9:0] O_JUMP  = 10'b00_1010_0001;
    localparam logic [9:0] O_HALT  = 10'b11_0101_0000;
    localparam logic [9:0] O_SWTCH = 10'b00_0000_0110;
    localparam logic [9:0] O_RST   = 10'b00_1010_1000;

    logic clk = 1'b0;
    logic rst;
    logic [REG_AW-1:0] ID_rs1_addr, ID_rs2_addr, EX_rd_addr;
    logic ID_use_rs1, ID_use_rs2, EX_mem_read, EX_valid, EX_jump;
    logic imem_busy, dmem_busy, trap_req;
    logic pc_halt, if_id_halt, if_id_flush, id_ex_halt, id_ex_flush;
    logic ex_mem_halt, ex_mem_flush, switch, pc_redirect_trap, pc_redirect_jump;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [CNT_W-1:0] exp_stall, exp_flush;

    pipe_hazard_ctrl #(.CNT_W(CNT_W), .REG_AW(REG_AW)) dut (
        .clk(clk), .rst(rst),
        .ID_rs1_addr(ID_rs1_addr), .ID_rs2_addr(ID_rs2_addr),
        .ID_use_rs1(ID_use_rs1), .ID_use_rs2(ID_use_rs2),
        .EX_rd_addr(EX_rd_addr), .EX_mem_read(EX_mem_read),
        .EX_valid(EX_valid), .EX_jump(EX_jump),
        .imem_busy(imem_busy), .dmem_busy(dmem_busy), .trap_req(trap_req),
        .pc_halt(pc_halt), .if_id_halt(if_id_halt), .if_id_flush(if_id_flush),
        .id_ex_halt(id_ex_halt), .id_ex_flush(id_ex_flush),
        .ex_mem_halt(ex_mem_halt), .ex_mem_flush(ex_mem_flush),
        .switch(switch), .pc_redirect_trap(pc_redirect_trap),
        .pc_redirect_jump(pc_redirect_jump),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [9:0] outs();
        return {pc_halt, if_id_halt, if_id_flush, id_ex_halt, id_ex_flush,
                ex_mem_halt, ex_mem_flush, switch, pc_redirect_trap, pc_redirect_jump};
    endfunction

    task automatic check_outs(input string tag, input logic [9:0] exp_out);
        n_cmp++;
        assert (outs() === exp_out) else begin
            n_fail++;
            $error("FAIL %s outputs: observed %b expected %b", tag, outs(), exp_out);
        end
    endtask

    task automatic check_cnts(input string tag);
        n_cmp++;
        assert (stall_cnt === exp_stall) else begin
            n_fail++;
            $error("FAIL %s stall_cnt: observed %0d expected %0d", tag, stall_cnt, exp_stall);
        end
        n_cmp++;
        assert (flush_cnt === exp_flush) else begin
            n_fail++;
            $error("FAIL %s flush_cnt: observed %0d expected %0d", tag, flush_cnt, exp_flush);
        end
    endtask

    // Inputs are already set; check this cycle's outputs, advance the counter model, clock, check counters.
    task automatic step(input string tag, input logic [9:0] exp_out);
        #1;
        check_outs(tag, exp_out);
        if (exp_out[9] && exp_stall != '1) exp_stall++;
        if ((exp_out[7] | exp_out[5] | exp_out[3] | exp_out[2]) && exp_flush != '1) exp_flush++;
        @(posedge clk);
        #1;
        check_cnts(tag);
    endtask

    task automatic idle_inputs();
        ID_rs1_addr = '0; ID_rs2_addr = '0; ID_use_rs1 = 0; ID_use_rs2 = 0;
        EX_rd_addr = '0; EX_mem_read = 0; EX_valid = 0; EX_jump = 0;
        imem_busy = 0; dmem_busy = 0; trap_req = 0;
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        exp_stall = '0;
        exp_flush = '0;
        @(posedge clk);
        #2;
        check_outs("in_reset", O_RST);
        check_cnts("in_reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        step("idle", O_NONE);

        // ld x5 in EX, add reading x5 in ID
        EX_valid = 1; EX_mem_read = 1; EX_rd_addr = 5'd5; ID_rs1_addr = 5'd5; ID_use_rs1 = 1;
        step("lduse_rs1", O_LDUSE);
        EX_mem_read = 0;
        step("after_lduse", O_NONE);

        EX_mem_read = 1; ID_use_rs1 = 0;
        step("rs1_match_unused", O_NONE);
        ID_rs2_addr = 5'd5; ID_use_rs2 = 1;
        step("lduse_rs2", O_LDUSE);
        EX_rd_addr = 5'd0; ID_rs2_addr = 5'd0; ID_rs1_addr = 5'd0; ID_use_rs1 = 1;
        step("rd_zero", O_NONE);
        EX_rd_addr = 5'd7; ID_rs1_addr = 5'd6; ID_rs2_addr = 5'd8;
        step("no_match", O_NONE);
        EX_valid = 0; ID_rs1_addr = 5'd7;
        step("ex_invalid", O_NONE);

        idle_inputs();
        EX_jump = 1;
        step("jump", O_JUMP);
        EX_jump = 0;
        step("after_jump", O_NONE);

        // Load-use and jump together: bubble wins
        EX_valid = 1; EX_mem_read = 1; EX_rd_addr = 5'd9; ID_rs1_addr = 5'd9; ID_use_rs1 = 1; EX_jump = 1;
        step("lduse_over_jump", O_LDUSE);
        // Memory wait outranks load-use
        imem_busy = 1;
        step("imem_over_lduse", O_HALT);
        idle_inputs();
        dmem_busy = 1;
        step("dmem_busy", O_HALT);

        // Trap with data access outstanding: drain then switch
        trap_req = 1; dmem_busy = 1;
        step("trap_drain_0", O_HALT);
        trap_req = 0;
        step("drain_1", O_HALT);
        trap_req = 1;
        step("drain_ignore_trap", O_HALT);
        trap_req = 0; dmem_busy = 0;
        step("drain_exit", O_HALT);
        step("switch", O_SWTCH);
        step("after_switch", O_NONE);

        // Trap with no outstanding access, even with a jump present
        trap_req = 1; EX_jump = 1;
        step("trap_direct", O_NONE);
        trap_req = 0; EX_jump = 0;
        step("switch_direct", O_SWTCH);
        step("after_switch_direct", O_NONE);

        // Drive stall_cnt into saturation
        imem_busy = 1;
        for (int i = 0; i < 12; i++) step("stall_sat", O_HALT);
        imem_busy = 0;
        n_cmp++;
        assert (stall_cnt === 4'hF) else begin
            n_fail++;
            $error("FAIL stall_saturated: observed %0d expected 15", stall_cnt);
        end

        // Drive flush_cnt into saturation
        EX_jump = 1;
        for (int i = 0; i < 12; i++) step("flush_sat", O_JUMP);
        EX_jump = 0;
        n_cmp++;
        assert (flush_cnt === 4'hF) else begin
            n_fail++;
            $error("FAIL flush_saturated: observed %0d expected 15", flush_cnt);
        end

        // Reset in the middle of DRAIN abandons the trap
        trap_req = 1; dmem_busy = 1;
        step("trap_drain_rst", O_HALT);
        trap_req = 0;
        #2;
        rst = 1'b1;
        #1;
        exp_stall = '0;
        exp_flush = '0;
        check_outs("async_rst", O_RST);
        check_cnts("async_rst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        dmem_busy = 0;
        step("post_rst_0", O_NONE);
        step("post_rst_1", O_NONE);
        step("post_rst_2", O_NONE);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
